tlb_op_sequencer: RTL and testbench

//  Sequences the WB-stage TLB maintenance ops (tlbsrch, tlbrd, tlbwr, tlbfill, invtlb) onto the single

---
 rtl/tlb_op_sequencer.sv | 137 +++++++++++++
 tb/tb_tlb_op_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_sequencer.sv
// Sequences WB-stage TLB maintenance ops onto the shared TLB port: accept -> EXEC -> RESP.
// Each op completes exactly two cycles after accept unless cancelled or reset.
module tlb_op_sequencer #(
  parameter int unsigned TLBNUM     = 16,
  parameter int unsigned TLBNUM_IDX = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  output logic                  req_ready,
  input  logic                  cancel,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_va,
  input  logic [TLBNUM_IDX-1:0] csr_tlbidx,
  input  logic [18:0]           csr_vppn,
  input  logic [9:0]            csr_asid,
  output logic                  tlb_s_en,
  output logic [18:0]           tlb_s_vppn,
  output logic [9:0]            tlb_s_asid,
  input  logic                  tlb_s_found,
  input  logic [TLBNUM_IDX-1:0] tlb_s_index,
  output logic [TLBNUM_IDX-1:0] tlb_r_index,
  output logic                  tlb_we,
  output logic [TLBNUM_IDX-1:0] tlb_w_index,
  output logic                  tlb_inv_en,
  output logic [4:0]            tlb_inv_op,
  output logic [9:0]            tlb_inv_asid,
  output logic [18:0]           tlb_inv_va,
  output logic                  done,
  output logic [2:0]            done_op,
  output logic                  srch_found,
  output logic [TLBNUM_IDX-1:0] srch_idx,
  output logic                  rd_commit,
  output logic                  refetch_req
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [TLBNUM_IDX-1:0] FILL_LAST = TLBNUM_IDX'(TLBNUM - 1);

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q;
  logic [18:0]           vppn_q;
  logic [9:0]            asid_q;
  logic [TLBNUM_IDX-1:0] r_idx_q;
  logic [TLBNUM_IDX-1:0] w_idx_q;
  logic [4:0]            inv_op_q;
  logic [9:0]            inv_asid_q;
  logic [18:0]           inv_va_q;
  logic [TLBNUM_IDX-1:0] fill_cnt_q;
  logic                  srch_found_q;
  logic [TLBNUM_IDX-1:0] srch_idx_q;

  logic accept;
  logic in_exec;
  logic in_resp;

  always_comb begin
    accept  = (state_q == ST_IDLE) && req_valid && !cancel;
    // Reset and cancel both kill every strobe and pulse in the cycle they are seen
    in_exec = resetn && !cancel && (state_q == ST_EXEC);
    in_resp = resetn && !cancel && (state_q == ST_RESP);

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = cancel ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      vppn_q       <= '0;
      asid_q       <= '0;
      r_idx_q      <= '0;
      w_idx_q      <= '0;
      inv_op_q     <= '0;
      inv_asid_q   <= '0;
      inv_va_q     <= '0;
      fill_cnt_q   <= '0;
      srch_found_q <= 1'b0;
      srch_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= (fill_cnt_q == FILL_LAST) ? '0 : fill_cnt_q + TLBNUM_IDX'(1);
      if (accept) begin
        op_q       <= req_op;
        vppn_q     <= csr_vppn;
        asid_q     <= csr_asid;
        r_idx_q    <= csr_tlbidx;
        w_idx_q    <= (req_op == OP_FILL) ? fill_cnt_q : csr_tlbidx;
        inv_op_q   <= inv_op;
        inv_asid_q <= inv_asid;
        inv_va_q   <= inv_va;
      end
      // A search miss keeps the previous hit index
      if (in_resp && (op_q == OP_SRCH)) begin
        srch_found_q <= tlb_s_found;
        if (tlb_s_found) srch_idx_q <= tlb_s_index;
      end
    end
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    tlb_s_en     = in_exec && (op_q == OP_SRCH);
    tlb_we       = in_exec && ((op_q == OP_WR) || (op_q == OP_FILL));
    tlb_inv_en   = in_exec && (op_q == OP_INV);
    tlb_s_vppn   = vppn_q;
    tlb_s_asid   = asid_q;
    tlb_r_index  = r_idx_q;
    tlb_w_index  = w_idx_q;
    tlb_inv_op   = inv_op_q;
    tlb_inv_asid = inv_asid_q;
    tlb_inv_va   = inv_va_q;
    done         = in_resp;
    done_op      = in_resp ? op_q : 3'd0;
    rd_commit    = in_resp && (op_q == OP_RD);
    refetch_req  = in_resp && ((op_q == OP_WR) || (op_q == OP_FILL) || (op_q == OP_INV));
    srch_found   = srch_found_q;
    srch_idx     = srch_idx_q;
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Randomized bench for tlb_op_sequencer against a transaction-level model
// that tracks each accepted op by its age in cycles.
module tb_tlb_op_sequencer;

  localparam int unsigned TLBNUM     = 16;
  localparam int unsigned TLBNUM_IDX = 4;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  req_valid;
  logic [2:0]            req_op;
  logic                  req_ready;
  logic                  cancel;
  logic [4:0]            inv_op;
  logic [9:0]            inv_asid;
  logic [18:0]           inv_va;
  logic [TLBNUM_IDX-1:0] csr_tlbidx;
  logic [18:0]           csr_vppn;
  logic [9:0]            csr_asid;
  logic                  tlb_s_en;
  logic [18:0]           tlb_s_vppn;
  logic [9:0]            tlb_s_asid;
  logic                  tlb_s_found;
  logic [TLBNUM_IDX-1:0] tlb_s_index;
  logic [TLBNUM_IDX-1:0] tlb_r_index;
  logic                  tlb_we;
  logic [TLBNUM_IDX-1:0] tlb_w_index;
  logic                  tlb_inv_en;
  logic [4:0]            tlb_inv_op;
  logic [9:0]            tlb_inv_asid;
  logic [18:0]           tlb_inv_va;
  logic                  done;
  logic [2:0]            done_op;
  logic                  srch_found;
  logic [TLBNUM_IDX-1:0] srch_idx;
  logic                  rd_commit;
  logic                  refetch_req;

  tlb_op_sequencer #(
    .TLBNUM    (TLBNUM),
    .TLBNUM_IDX(TLBNUM_IDX)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_ready   (req_ready),
    .cancel      (cancel),
    .inv_op      (inv_op),
    .inv_asid    (inv_asid),
    .inv_va      (inv_va),
    .csr_tlbidx  (csr_tlbidx),
    .csr_vppn    (csr_vppn),
    .csr_asid    (csr_asid),
    .tlb_s_en    (tlb_s_en),
    .tlb_s_vppn  (tlb_s_vppn),
    .tlb_s_asid  (tlb_s_asid),
    .tlb_s_found (tlb_s_found),
    .tlb_s_index (tlb_s_index),
    .tlb_r_index (tlb_r_index),
    .tlb_we      (tlb_we),
    .tlb_w_index (tlb_w_index),
    .tlb_inv_en  (tlb_inv_en),
    .tlb_inv_op  (tlb_inv_op),
    .tlb_inv_asid(tlb_inv_asid),
    .tlb_inv_va  (tlb_inv_va),
    .done        (done),
    .done_op     (done_op),
    .srch_found  (srch_found),
    .srch_idx    (srch_idx),
    .rd_commit   (rd_commit),
    .refetch_req (refetch_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Model: age of the op in flight (0 = none, 1 = port cycle, 2 = response cycle)
  int          age;
  int          cyc;
  logic [2:0]  t_op;
  logic [18:0] t_vppn;
  logic [9:0]  t_asid;
  logic [3:0]  t_idx;
  logic [3:0]  t_fill;
  logic [4:0]  t_iop;
  logic [9:0]  t_iasid;
  logic [18:0] t_iva;
  logic        m_found;
  logic [3:0]  m_sidx;

  // Caller drives sampled inputs and TLB responses; this drives handshake/reset and checks.
  task automatic step(input logic v, input logic [2:0] op, input logic c, input logic rn);
    logic e_sen, e_we, e_inv, e_done, wr_like;
    req_valid = v;
    req_op    = op;
    cancel    = c;
    resetn    = rn;
    @(negedge clk);
    wr_like = (t_op == 3'd2) || (t_op == 3'd3);
    e_sen  = rn && !c && age == 1 && t_op == 3'd0;
    e_we   = rn && !c && age == 1 && wr_like;
    e_inv  = rn && !c && age == 1 && t_op == 3'd4;
    e_done = rn && !c && age == 2;
    check("s_en", 32'(tlb_s_en), 32'(e_sen));
    check("we", 32'(tlb_we), 32'(e_we));
    check("inv_en", 32'(tlb_inv_en), 32'(e_inv));
    check("done", 32'(done), 32'(e_done));
    check("done_op", 32'(done_op), e_done ? 32'(t_op) : 32'd0);
    check("rd_commit", 32'(rd_commit), 32'(e_done && t_op == 3'd1));
    check("refetch", 32'(refetch_req), 32'(e_done && (wr_like || t_op == 3'd4)));
    check("srch_found", 32'(srch_found), 32'(m_found));
    check("srch_idx", 32'(srch_idx), 32'(m_sidx));
    if (rn) check("req_ready", 32'(req_ready), 32'(age == 0));
    if (e_we) check("w_index", 32'(tlb_w_index), t_op == 3'd3 ? 32'(t_fill) : 32'(t_idx));
    if (e_sen) begin
      check("s_vppn", 32'(tlb_s_vppn), 32'(t_vppn));
      check("s_asid", 32'(tlb_s_asid), 32'(t_asid));
    end
    if (e_inv) begin
      check("inv_op", 32'(tlb_inv_op), 32'(t_iop));
      check("inv_asid", 32'(tlb_inv_asid), 32'(t_iasid));
      check("inv_va", 32'(tlb_inv_va), 32'(t_iva));
    end
    if (rn && age > 0 && t_op == 3'd1) check("r_index", 32'(tlb_r_index), 32'(t_idx));
    @(posedge clk);
    if (!rn) begin
      age = 0; cyc = 0; m_found = 1'b0; m_sidx = '0;
    end else begin
      if (age == 0) begin
        if (v && !c) begin
          age = 1; t_op = op; t_vppn = csr_vppn; t_asid = csr_asid; t_idx = csr_tlbidx;
          t_fill = 4'(cyc % TLBNUM); t_iop = inv_op; t_iasid = inv_asid; t_iva = inv_va;
        end
      end else if (age == 1) begin
        age = c ? 0 : 2;
      end else begin
        if (!c && t_op == 3'd0) begin
          m_found = tlb_s_found;
          if (tlb_s_found) m_sidx = tlb_s_index;
        end
        age = 0;
      end
      cyc++;
    end
    #1;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; cancel = 1'b0;
    inv_op = '0; inv_asid = '0; inv_va = '0; csr_tlbidx = '0; csr_vppn = '0; csr_asid = '0;
    tlb_s_found = 1'b0; tlb_s_index = '0;
    t_op = '0; t_vppn = '0; t_asid = '0; t_idx = '0; t_fill = '0;
    t_iop = '0; t_iasid = '0; t_iva = '0;
    repeat (2) @(posedge clk);
    #1;
    age = 0; cyc = 0; m_found = 1'b0; m_sidx = '0;
    check("rst_s_vppn", 32'(tlb_s_vppn), 32'd0);
    check("rst_w_index", 32'(tlb_w_index), 32'd0);
    check("rst_r_index", 32'(tlb_r_index), 32'd0);
    check("rst_inv_va", 32'(tlb_inv_va), 32'd0);

    // Fills accepted at cycles 5 and 8 after reset release target entries 5 and 8
    repeat (5) step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd3, 1'b0, 1'b1);
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b1, 3'd3, 1'b0, 1'b1);
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b1);

    // SRCH hit at idx 7
    csr_vppn = 19'h12345; csr_asid = 10'h5;
    step(1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    tlb_s_found = 1'b1; tlb_s_index = 4'd7;
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);

    // WR idx 3, RD idx 9
    csr_tlbidx = 4'd3;
    step(1'b1, 3'd2, 1'b0, 1'b1);
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b1);
    csr_tlbidx = 4'd9;
    step(1'b1, 3'd1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b1);

    // INV cancelled in EXEC, then a new request accepted straight away
    inv_op = 5'd5; inv_asid = 10'h3; inv_va = 19'h100;
    step(1'b1, 3'd4, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b1, 3'd7, 1'b0, 1'b1);
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b1);

    // Reset during RESP of a SRCH
    tlb_s_found = 1'b1; tlb_s_index = 4'd2;
    step(1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      inv_op      = 5'($urandom);
      inv_asid    = 10'($urandom);
      inv_va      = 19'($urandom);
      csr_tlbidx  = 4'($urandom);
      csr_vppn    = 19'($urandom);
      csr_asid    = 10'($urandom);
      tlb_s_found = 1'($urandom);
      tlb_s_index = 4'($urandom);
      step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
